// File: rtl/prime_pkg.sv
`default_nettype none
// ============================================================================
// Module      : prime_pkg
// Description : Shared constants, FSM state encoding and width helpers for
//               the prime table engine.
// Revision    : 1.0 - initial release
// ============================================================================
package prime_pkg;

  localparam int DEF_N_WIDTH    = 10;
  localparam int DEF_MAX_PRIMES = 168;

  // Engine FSM state encoding
  typedef logic [2:0] state_t;
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_INIT  = 3'd1;
  localparam logic [2:0] ST_CHECK = 3'd2;
  localparam logic [2:0] ST_DIV   = 3'd3;
  localparam logic [2:0] ST_STORE = 3'd4;
  localparam logic [2:0] ST_NEXT  = 3'd5;
  localparam logic [2:0] ST_DONE  = 3'd6;

  // Read index width; a one-entry table still needs a 1-bit index
  function automatic int idx_width(input int max_primes);
    return (max_primes > 1) ? $clog2(max_primes) : 1;
  endfunction

  // Count width: must represent 0..max_primes inclusive
  function automatic int cnt_width(input int max_primes);
    return $clog2(max_primes + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/prime_table_engine_if.sv
`default_nettype none
// ============================================================================
// Module      : prime_table_engine_if
// Description : Control, status and read-port bundle of the prime table
//               engine. master = controller/UI side, slave = engine side.
// Revision    : 1.0 - initial release
// ============================================================================
interface prime_table_engine_if #(
  parameter int N_WIDTH    = prime_pkg::DEF_N_WIDTH,
  parameter int MAX_PRIMES = prime_pkg::DEF_MAX_PRIMES
);
  import prime_pkg::*;

  localparam int IDX_W = idx_width(MAX_PRIMES);
  localparam int CNT_W = cnt_width(MAX_PRIMES);

  logic               start;
  logic [N_WIDTH-1:0] bound;
  logic               abort;
  logic               busy;
  logic               done;
  logic [CNT_W-1:0]   prime_count;
  logic               overflow;
  logic [N_WIDTH-1:0] cur_cand;
  logic [IDX_W-1:0]   rd_idx;
  logic [N_WIDTH-1:0] rd_data;
  logic               rd_valid;

  modport master (
    output start, bound, abort, rd_idx,
    input  busy, done, prime_count, overflow, cur_cand, rd_data, rd_valid
  );

  modport slave (
    input  start, bound, abort, rd_idx,
    output busy, done, prime_count, overflow, cur_cand, rd_data, rd_valid
  );

endinterface
`default_nettype wire

// File: rtl/prime_rem_seq.sv
`default_nettype none
// ============================================================================
// Module      : prime_rem_seq
// Description : Restoring sequential remainder unit. One quotient bit per
//               cycle; done pulses N_WIDTH+1 cycles after go. A go while
//               busy restarts the operation. Divisor must be non-zero.
// Revision    : 1.0 - initial release
// ============================================================================
module prime_rem_seq
  import prime_pkg::*;
#(
  parameter int N_WIDTH = DEF_N_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               go,
  input  logic [N_WIDTH-1:0] dividend,
  input  logic [N_WIDTH-1:0] divisor,
  output logic               busy,
  output logic               done,
  output logic [N_WIDTH-1:0] rem
);

  localparam int CW = $clog2(N_WIDTH + 1);

  logic [CW-1:0]      r_cnt;
  logic [N_WIDTH-1:0] r_dvd;
  logic [N_WIDTH-1:0] r_dsr;
  logic [N_WIDTH-1:0] r_rem;
  logic               r_busy;
  logic               r_done;

  logic [N_WIDTH:0]   w_trial;
  logic [N_WIDTH:0]   w_diff;

  // Partial remainder shifted left with the next dividend bit; the MSB of
  // the difference acts as the borrow (trial < divisor) indicator.
  assign w_trial = {r_rem, r_dvd[N_WIDTH-1]};
  assign w_diff  = w_trial - {1'b0, r_dsr};

  // Load on go, iterate N_WIDTH times, then pulse done for one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_dvd  <= '0;
      r_dsr  <= '0;
      r_rem  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (go) begin
        r_dvd  <= dividend;
        r_dsr  <= divisor;
        r_rem  <= '0;
        r_cnt  <= CW'(N_WIDTH);
        r_busy <= 1'b1;
      end else if (r_busy) begin
        if (r_cnt != '0) begin
          r_rem <= w_diff[N_WIDTH] ? w_trial[N_WIDTH-1:0] : w_diff[N_WIDTH-1:0];
          r_dvd <= {r_dvd[N_WIDTH-2:0], 1'b0};
          r_cnt <= r_cnt - CW'(1);
        end else begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign rem  = r_rem;

endmodule
`default_nettype wire

// File: rtl/prime_table_engine.sv
`default_nettype none
// ============================================================================
// Module      : prime_table_engine
// Description : Finds every prime <= bound by trial division against the
//               primes already found (only while p*p <= candidate) and
//               stores them in order. Registered indexed read port.
//               Optional macro PRIME_ODD_STEP_EN: step by 2 after the
//               candidate 2, so even candidates are never tested. Results
//               are identical either way; only run length changes.
// Revision    : 1.0 - initial release
// ============================================================================
module prime_table_engine
  import prime_pkg::*;
#(
  parameter int N_WIDTH    = DEF_N_WIDTH,
  parameter int MAX_PRIMES = DEF_MAX_PRIMES
) (
  input  logic                clk,
  input  logic                rst_n,
  prime_table_engine_if.slave bus
);

  localparam int IDX_W = idx_width(MAX_PRIMES);
  localparam int CNT_W = cnt_width(MAX_PRIMES);
  localparam int SW    = N_WIDTH + 1;
  localparam int QW    = 2 * N_WIDTH;

  localparam logic [CNT_W-1:0] c_max_cnt = CNT_W'(MAX_PRIMES);

  logic [2:0]         r_state;
  logic [N_WIDTH-1:0] r_bound;
  logic [N_WIDTH-1:0] r_cand;
  logic [CNT_W-1:0]   r_k;
  logic [CNT_W-1:0]   r_count;
  logic               r_overflow;
  logic               r_busy;
  logic               r_done;
  logic [N_WIDTH-1:0] r_rd_data;
  logic               r_rd_valid;
  logic [N_WIDTH-1:0] r_table [MAX_PRIMES];

  logic [N_WIDTH-1:0] w_divisor;
  logic [QW-1:0]      w_sq;
  logic               w_check_stop;
  logic               w_go;
  logic [SW-1:0]      w_step;
  logic [SW-1:0]      w_next_sum;
  logic               w_last;
  logic               w_full;
  logic               w_wr_en;
  logic               w_rd_hit;
  logic               w_rem_busy;
  logic               w_rem_done;
  logic [N_WIDTH-1:0] w_rem;

  // Divisor path: current trial prime; k never exceeds prime_count here
  assign w_divisor = (r_k < c_max_cnt) ? r_table[r_k[IDX_W-1:0]] : '0;

  // Full-width square so large divisors never alias below the candidate
  assign w_sq = {{N_WIDTH{1'b0}}, w_divisor} * {{N_WIDTH{1'b0}}, w_divisor};

  assign w_check_stop = (r_k == r_count) || (w_sq > {{N_WIDTH{1'b0}}, r_cand});
  assign w_go         = (r_state == ST_CHECK) && !w_check_stop && !bus.abort;

`ifdef PRIME_ODD_STEP_EN
  assign w_step = (r_cand == N_WIDTH'(2)) ? SW'(1) : SW'(2);
`else
  assign w_step = SW'(1);
`endif

  // One extra bit so the all-ones candidate cannot wrap back to small values
  assign w_next_sum = {1'b0, r_cand} + w_step;
  assign w_last     = (r_cand >= r_bound) || (w_next_sum > {1'b0, r_bound});

  assign w_full  = (r_count == c_max_cnt);
  assign w_wr_en = (r_state == ST_STORE) && !w_full && !bus.abort;

  prime_rem_seq #(
    .N_WIDTH (N_WIDTH)
  ) u_rem (
    .clk      (clk),
    .rst_n    (rst_n),
    .go       (w_go),
    .dividend (r_cand),
    .divisor  (w_divisor),
    .busy     (w_rem_busy),
    .done     (w_rem_done),
    .rem      (w_rem)
  );

  // Table write port; contents are not reset, validity comes from prime_count
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_table[r_count[IDX_W-1:0]] <= r_cand;
    end
  end

  // Main sequencer; abort overrides every state and suppresses done
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_bound    <= '0;
      r_cand     <= '0;
      r_k        <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (bus.abort) begin
        r_state <= ST_IDLE;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE, ST_DONE: begin
            if (bus.start) begin
              r_bound    <= bus.bound;
              r_count    <= '0;
              r_overflow <= 1'b0;
              r_cand     <= N_WIDTH'(2);
              r_k        <= '0;
              r_busy     <= 1'b1;
              r_state    <= ST_INIT;
            end
          end
          ST_INIT: begin
            if (r_bound < N_WIDTH'(2)) begin
              r_state <= ST_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state <= ST_STORE;
            end
          end
          ST_CHECK: begin
            r_state <= w_check_stop ? ST_STORE : ST_DIV;
          end
          ST_DIV: begin
            if (w_rem_done && !w_rem_busy) begin
              if (w_rem == '0) begin
                r_state <= ST_NEXT;
              end else begin
                r_k     <= r_k + CNT_W'(1);
                r_state <= ST_CHECK;
              end
            end
          end
          ST_STORE: begin
            if (!w_full) begin
              r_count <= r_count + CNT_W'(1);
              r_state <= ST_NEXT;
            end else begin
              r_overflow <= 1'b1;
              r_state    <= ST_DONE;
              r_busy     <= 1'b0;
              r_done     <= 1'b1;
            end
          end
          ST_NEXT: begin
            if (w_last) begin
              r_state <= ST_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_cand  <= w_next_sum[N_WIDTH-1:0];
              r_k     <= '0;
              r_state <= ST_CHECK;
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  // User read port, independent of the sequencer state
  assign w_rd_hit = (CNT_W'(bus.rd_idx) < r_count);

  // Registered read: zero data whenever the index is beyond the valid entries
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_rd_valid <= w_rd_hit;
      r_rd_data  <= w_rd_hit ? r_table[bus.rd_idx] : '0;
    end
  end

  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.prime_count = r_count;
  assign bus.overflow    = r_overflow;
  assign bus.cur_cand    = r_cand;
  assign bus.rd_data     = r_rd_data;
  assign bus.rd_valid    = r_rd_valid;

endmodule
`default_nettype wire

// File: tb/tb_prime_table_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_prime_table_engine
// Description : Directed self-checking bench for prime_table_engine.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prime_table_engine;

  localparam int NW = 10;
  localparam int MP = 168;
  localparam int IW = 8;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  prime_table_engine_if #(.N_WIDTH(NW), .MAX_PRIMES(MP)) bus ();

  prime_table_engine #(
    .N_WIDTH    (NW),
    .MAX_PRIMES (MP)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_start(input int b);
    @(negedge clk);
    bus.bound = NW'(b);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget, output int cycles);
    logic seen;
    seen   = 1'b0;
    cycles = 0;
    while (!seen && cycles < budget) begin
      @(negedge clk);
      cycles++;
      if (bus.done === 1'b1) seen = 1'b1;
    end
    check(tag, 32'(seen), 32'd1);
  endtask

  task automatic rd(input int idx, output logic [31:0] data, output logic [31:0] valid);
    @(negedge clk);
    bus.rd_idx = IW'(idx);
    @(negedge clk);
    data  = 32'(bus.rd_data);
    valid = 32'(bus.rd_valid);
  endtask

  initial begin
    int          cyc;
    logic [31:0] d;
    logic [31:0] v;
    logic        seen;

    errors    = 0;
    checks    = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.bound = '0;
    bus.abort = 1'b0;
    bus.rd_idx = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_count", 32'(bus.prime_count), 0);
    check("rst_ovf", 32'(bus.overflow), 0);
    check("rst_cand", 32'(bus.cur_cand), 0);
    check("rst_rd_valid", 32'(bus.rd_valid), 0);
    check("rst_rd_data", 32'(bus.rd_data), 0);
    rst_n = 1'b1;

    // bound = 30: 2 3 5 7 11 13 17 19 23 29
    do_start(30);
    check("b30_busy", 32'(bus.busy), 1);
    wait_done("b30_done_seen", 5000, cyc);
    $display("info: bound=30 run cycles=%0d", cyc);
    check("b30_busy_low", 32'(bus.busy), 0);
    check("b30_count", 32'(bus.prime_count), 10);
    check("b30_ovf", 32'(bus.overflow), 0);
    @(negedge clk);
    check("b30_done_one_cycle", 32'(bus.done), 0);
    rd(9, d, v);
    check("b30_rd9_data", d, 29);
    check("b30_rd9_valid", v, 1);
    rd(0, d, v);
    check("b30_rd0_data", d, 2);
    rd(4, d, v);
    check("b30_rd4_data", d, 11);
    rd(10, d, v);
    check("b30_rd10_valid", v, 0);
    check("b30_rd10_data", d, 0);

    // bound = 1 and 0: no primes, done quickly
    do_start(1);
    wait_done("b1_done_seen", 20, cyc);
    check("b1_fast", 32'(cyc <= 3), 1);
    check("b1_count", 32'(bus.prime_count), 0);
    do_start(0);
    wait_done("b0_done_seen", 20, cyc);
    check("b0_fast", 32'(cyc <= 3), 1);
    check("b0_count", 32'(bus.prime_count), 0);

    // bound = 2: single entry
    do_start(2);
    wait_done("b2_done_seen", 100, cyc);
    check("b2_count", 32'(bus.prime_count), 1);
    rd(0, d, v);
    check("b2_rd0_data", d, 2);
    check("b2_rd0_valid", v, 1);
    rd(1, d, v);
    check("b2_rd1_valid", v, 0);

    // bound = 100 with a second start mid-run that must be ignored
    do_start(100);
    repeat (18) @(negedge clk);
    check("b100_busy_at_restart", 32'(bus.busy), 1);
    bus.bound = NW'(10);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done("b100_done_seen", 20000, cyc);
    check("b100_count", 32'(bus.prime_count), 25);
    rd(24, d, v);
    check("b100_rd24_data", d, 97);
    rd(12, d, v);
    check("b100_rd12_data", d, 41);

    // bound = 500, abort once the candidate has moved past 101
    do_start(500);
    cyc = 0;
    while (bus.cur_cand <= NW'(101) && cyc < 30000) begin
      @(negedge clk);
      cyc++;
    end
    check("abort_reached_101", 32'(bus.cur_cand > NW'(101)), 1);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check("abort_busy", 32'(bus.busy), 0);
    check("abort_done", 32'(bus.done), 0);
    check("abort_count", 32'(bus.prime_count), 26);
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (bus.done === 1'b1) seen = 1'b1;
    end
    check("abort_no_done", 32'(seen), 0);
    rd(25, d, v);
    check("abort_rd25_data", d, 101);
    do_start(13);
    wait_done("b13_done_seen", 2000, cyc);
    check("b13_count", 32'(bus.prime_count), 6);
    rd(5, d, v);
    check("b13_rd5_data", d, 13);
    check("b13_ovf", 32'(bus.overflow), 0);

    // bound = 1023: table fills at 997, 1009 sets overflow
    do_start(1023);
    wait_done("b1023_done_seen", 70000, cyc);
    $display("info: bound=1023 run cycles=%0d", cyc);
    check("b1023_count", 32'(bus.prime_count), 168);
    check("b1023_ovf", 32'(bus.overflow), 1);
    rd(167, d, v);
    check("b1023_rd167_data", d, 997);
    check("b1023_rd167_valid", v, 1);
    rd(168, d, v);
    check("b1023_rd168_valid", v, 0);

    // Async reset in the middle of a run
    do_start(200);
    repeat (50) @(negedge clk);
    bus.rd_idx = IW'(3);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(bus.busy), 0);
    check("arst_count", 32'(bus.prime_count), 0);
    check("arst_cand", 32'(bus.cur_cand), 0);
    check("arst_ovf", 32'(bus.overflow), 0);
    check("arst_done", 32'(bus.done), 0);
    check("arst_rd_valid", 32'(bus.rd_valid), 0);
    check("arst_rd_data", 32'(bus.rd_data), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/prime_table_engine.md
Name: prime_table_engine

Overview:
- Parametrised prime-table generator for the prime finder: on a start pulse, finds every prime ≤ `bound` and stores them in order in an internal table.
- Tests candidates by trial division using only previously found primes p with p*p ≤ candidate. Each division runs on a sequential remainder unit, not a combinational `%`.
- Exposes prime count, overflow flag and a registered indexed read port. The display/UI layer uses the read port for both the "all primes" and "Nth prime" views.

Parameters:
- N_WIDTH, 10, width of bound, candidates and stored primes.
- MAX_PRIMES, 168, table depth.
- IDX_W (derived), $clog2(MAX_PRIMES), read index width.
- CNT_W (derived), $clog2(MAX_PRIMES+1), count width.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; accepted only in IDLE or DONE
- bound  in  N_WIDTH  upper bound, sampled on the accepted start
- abort  in  1  stop the run; highest priority after reset
- busy  out  1  high from the cycle after start until DONE/IDLE
- done  out  1  one-cycle pulse on run completion
- prime_count  out  CNT_W  number of valid table entries
- overflow  out  1  a prime was found while the table was full
- cur_cand  out  N_WIDTH  candidate under test (progress display)
- rd_idx  in  IDX_W  read index (0-based)
- rd_data  out  N_WIDTH  table[rd_idx], registered, 1-cycle latency
- rd_valid  out  1  registered; high when rd_idx < prime_count in the sampling cycle

Behaviour:
- Reset (async, rst_n=0): all outputs 0, state IDLE, cur_cand 0. Table contents need not be cleared; validity comes from prime_count.
- States: IDLE, INIT, CHECK, DIV, STORE, NEXT, DONE.
- IDLE/DONE + start → INIT:
  - latch bound; clear prime_count and overflow; cand=2; busy=1.
  - start while busy is ignored.
- INIT:
  - bound<2 → DONE.
  - otherwise store 2 → STORE, then set cand=3.
- CHECK, with divisor pointer k from 0:
  - if k==prime_count or table[k]^2 > cand → STORE. The square is computed 2*N_WIDTH bits wide with no truncation.
  - otherwise launch the remainder unit on (cand, table[k]) → DIV.
- DIV:
  - wait for the remainder unit's done.
  - rem==0 → NEXT (composite).
  - else k++ → CHECK.
- STORE:
  - if prime_count<MAX_PRIMES: table[prime_count]=cand, prime_count++.
  - else set overflow (sticky until next start) → DONE.
  - otherwise → NEXT.
- NEXT:
  - if cand ≥ bound or cand == all-ones → DONE. No wrap-around.
  - else cand += step, k=0 → CHECK.
  - If cand+step exceeds bound → DONE.
- DONE: done=1 for exactly one cycle on entry; busy=0. Results hold until the next start.
- abort (any busy state): → IDLE next cycle.
  - busy=0, done not pulsed.
  - prime_count/table keep the partial results; the in-flight divide is discarded.
- cur_cand follows cand while busy and holds its last value otherwise.
- Read port:
  - fully independent of state; usable during a run (reads may reflect partial results).
  - rd_data=0 when rd_valid=0.
- Table: single write port, one async/registered read for the divisor path plus one for the user read port. Two-read RAM or regs.

Optional Feature:
- Macro: PRIME_ODD_STEP_EN.
- Defined: step=2 after 2, so even candidates are never tested.
- Undefined: step=1; even candidates are rejected by division by table[0]=2.
- The resulting table, prime_count, overflow and done behaviour are identical either way. Only the run cycle count differs.

Decomposition:
- Package prime_pkg: state enum type, default N_WIDTH/MAX_PRIMES constants, count/index width functions.
- Sub-module prime_rem_seq:
  - restoring sequential remainder; ports clk, rst_n, go, dividend, divisor, busy, done, rem.
  - latency N_WIDTH+1 cycles from go to done; divisor ≥ 2 guaranteed by the caller.

Test Plan:
- bound=30, start → done after finite cycles; prime_count=10, overflow=0; rd_idx=9 → rd_data=29, rd_valid=1 one cycle later; rd_idx=10 → rd_valid=0, rd_data=0.
- bound=1 and bound=0 → done within 3 cycles, prime_count=0; bound=2 → prime_count=1, table[0]=2.
- Defaults, bound=1023 → prime_count=168, table[167]=997, overflow=1 (1009 found while full).
- bound=100, start; second start with bound=10 at cycle 20 → ignored; final prime_count=25, table[24]=97.
- bound=500, abort asserted when cur_cand reaches 101 → busy=0 next cycle, no done pulse, prime_count=26. A new start with bound=13 → prime_count=6.
- Async reset mid-run → all outputs 0 immediately. Run each test with and without PRIME_ODD_STEP_EN; compare the tables (must match) and cycle counts (must be fewer with the macro defined).
